// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS constants and helpers
package tmds_pkg;

  localparam int TMDS_TOKEN_W = 10;

  // The four TMDS control-period tokens, indexed by {c1, c0}
  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    case (c)
      2'b00:   return CTRL_TOKEN_00;
      2'b01:   return CTRL_TOKEN_01;
      2'b10:   return CTRL_TOKEN_10;
      default: return CTRL_TOKEN_11;
    endcase
  endfunction

  // Clock lane: high for the first half of the word, low for the second
  function automatic logic [63:0] clk_lane_pattern(input int unsigned token_w);
    return (64'd1 << (token_w / 2)) - 64'd1;
  endfunction

endpackage

// File: rtl/tmds_lane_shifter.sv
// rtl/tmds_lane_shifter.sv - one lane's load / shift-by-two register
module tmds_lane_shifter
  import tmds_pkg::*;
#(
  parameter int TOKEN_W = TMDS_TOKEN_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TOKEN_W-1:0] din,
  input  logic               inv,
  output logic               ddr_even,
  output logic               ddr_odd
);

  logic [TOKEN_W-1:0] sreg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din ^ {TOKEN_W{inv}};
    end else begin
      sreg <= {2'b00, sreg[TOKEN_W-1:2]};
    end
  end

  assign ddr_even = sreg[0];
  assign ddr_odd  = sreg[1];

endmodule

// File: rtl/tmds_ddr_serializer_n.sv
// rtl/tmds_ddr_serializer_n.sv - N-lane TMDS DDR serializer with handshake and resync
module tmds_ddr_serializer_n
  import tmds_pkg::*;
#(
  parameter int                 NUM_CHAN   = 3,
  parameter int                 TOKEN_W    = TMDS_TOKEN_W,
  parameter int                 CLK_LANE   = 1,
  parameter logic [TOKEN_W-1:0] IDLE_TOKEN = TOKEN_W'(ctrl_token(2'b00)),
  localparam int                LANES      = NUM_CHAN + CLK_LANE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CHAN*TOKEN_W-1:0] tokens,
  input  logic                        tokens_valid,
  output logic                        tokens_ready,
  input  logic [LANES-1:0]            invert,
  input  logic                        resync,
  output logic                        underrun,
  input  logic                        underrun_clr,
  output logic [LANES-1:0]            ddr_even,
  output logic [LANES-1:0]            ddr_odd
);

  localparam int                 PHASES     = TOKEN_W / 2;
  localparam int                 PH_W       = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [PH_W-1:0]    PHASE_LAST = PH_W'(PHASES - 1);
  localparam logic [63:0]        CLK_PAT_W  = clk_lane_pattern(unsigned'(TOKEN_W));
  localparam logic [TOKEN_W-1:0] CLK_PAT    = CLK_PAT_W[TOKEN_W-1:0];

  logic [PH_W-1:0] phase;
  logic            load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (resync) begin
      phase <= PHASE_LAST;
    end else if (phase == PHASE_LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  assign tokens_ready = (phase == PHASE_LAST) && rst_n;
  assign load         = tokens_ready;

  // Set has priority over clear so an underrun is never silently lost
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else if (load && !tokens_valid) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [TOKEN_W-1:0] din;

    if (k < NUM_CHAN) begin : g_data
      assign din = tokens_valid ? tokens[k*TOKEN_W +: TOKEN_W] : IDLE_TOKEN;
    end else begin : g_clk
      assign din = CLK_PAT;
    end

    tmds_lane_shifter #(
      .TOKEN_W (TOKEN_W)
    ) u_shifter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .din      (din),
      .inv      (invert[k]),
      .ddr_even (ddr_even[k]),
      .ddr_odd  (ddr_odd[k])
    );
  end

endmodule
